// File: rtl/trap_ctrl.sv
// Trap / CSR-access sequencer for the multicycle core: runs one csrrw, csrrs,
// ecall or mret at a time against the machine-mode CSR file and returns rd/redirect.
module trap_ctrl #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            op,
  input  logic [11:0]           csr_idx,
  input  logic [DATA_WIDTH-1:0] rs1_data,
  input  logic                  rs1_zero,
  input  logic [DATA_WIDTH-1:0] pc,
  output logic                  csr_wen,
  output logic [DATA_WIDTH-1:0] csr_addr,
  output logic [DATA_WIDTH-1:0] csr_wdata,
  input  logic [DATA_WIDTH-1:0] csr_rdata,
  output logic                  intr,
  output logic [DATA_WIDTH-1:0] intr_NO,
  output logic [DATA_WIDTH-1:0] intr_epc,
  input  logic [DATA_WIDTH-1:0] intr_mtvec,
  input  logic [DATA_WIDTH-1:0] mret_mepc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  rd_wen,
  output logic [DATA_WIDTH-1:0] rd_wdata,
  output logic                  redirect,
  output logic [DATA_WIDTH-1:0] redirect_pc
);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_WR, S_TRAP, S_RESP} state_t;

  localparam logic [1:0] OP_CSRRW = 2'b00;
  localparam logic [1:0] OP_CSRRS = 2'b01;
  localparam logic [1:0] OP_ECALL = 2'b10;
  localparam logic [1:0] OP_MRET  = 2'b11;

  state_t                state_q, state_d;
  logic [1:0]            op_q;
  logic [11:0]           idx_q;
  logic [DATA_WIDTH-1:0] rs1_q;
  logic                  rs1_zero_q;
  logic [DATA_WIDTH-1:0] pc_q;
  logic [3:0]            cause_q;
  logic                  trap_q;
  logic [DATA_WIDTH-1:0] old_q;
  logic [DATA_WIDTH-1:0] target_q;

  logic                  accept;
  logic                  legal_idx;
  logic                  take_trap;
  logic [11:0]           addr12;
  logic [DATA_WIDTH-1:0] wr_val;

  assign accept    = in_valid && (state_q == S_IDLE);
  assign legal_idx = (csr_idx == 12'h300) || (csr_idx == 12'h305) ||
                     (csr_idx == 12'h341) || (csr_idx == 12'h342);
  assign take_trap = (op == OP_ECALL) || (!op[1] && !legal_idx);
  assign addr12    = (op_q == OP_MRET) ? 12'h300 : idx_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q       <= '0;
      idx_q      <= '0;
      rs1_q      <= '0;
      rs1_zero_q <= 1'b0;
      pc_q       <= '0;
      cause_q    <= '0;
      trap_q     <= 1'b0;
      old_q      <= '0;
      target_q   <= '0;
    end else begin
      if (accept) begin
        op_q       <= op;
        idx_q      <= csr_idx;
        rs1_q      <= rs1_data;
        rs1_zero_q <= rs1_zero;
        pc_q       <= pc;
        trap_q     <= take_trap;
        cause_q    <= (op == OP_ECALL) ? 4'd11 : 4'd2;
      end
      // mepc is captured alongside the mstatus read so mret's target is fixed
      // before its own mstatus write lands.
      if (state_q == S_RD) begin
        old_q    <= csr_rdata;
        target_q <= mret_mepc;
      end
      if (state_q == S_TRAP) target_q <= intr_mtvec;
    end
  end

  always_comb begin
    wr_val = rs1_q;
    case (op_q)
      OP_CSRRS: wr_val = old_q | rs1_q;
      OP_MRET: begin
        wr_val        = old_q;
        wr_val[3]     = old_q[7];
        wr_val[7]     = 1'b1;
        wr_val[12:11] = 2'b11;
      end
      default: wr_val = rs1_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    in_ready    = 1'b0;
    csr_wen     = 1'b0;
    csr_addr    = '0;
    csr_wdata   = '0;
    intr        = 1'b0;
    intr_NO     = '0;
    intr_epc    = '0;
    out_valid   = 1'b0;
    rd_wen      = 1'b0;
    rd_wdata    = '0;
    redirect    = 1'b0;
    redirect_pc = '0;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = take_trap ? S_TRAP : S_RD;
      end
      S_RD: begin
        csr_addr = {{(DATA_WIDTH-12){1'b0}}, addr12};
        state_d  = S_WR;
      end
      S_WR: begin
        csr_addr  = {{(DATA_WIDTH-12){1'b0}}, addr12};
        csr_wen   = !((op_q == OP_CSRRS) && rs1_zero_q);
        csr_wdata = wr_val;
        state_d   = S_RESP;
      end
      S_TRAP: begin
        intr     = 1'b1;
        intr_NO  = {{(DATA_WIDTH-4){1'b0}}, cause_q};
        intr_epc = pc_q;
        state_d  = S_RESP;
      end
      S_RESP: begin
        out_valid = 1'b1;
        if (trap_q || (op_q == OP_MRET)) begin
          redirect    = 1'b1;
          redirect_pc = target_q;
        end else begin
          rd_wen   = 1'b1;
          rd_wdata = old_q;
        end
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: doc/trap_ctrl.md
# trap_ctrl

Trap and CSR-access sequencer for the multicycle NPC core; it is the initiator side of the machine-mode CSR file's trap/return interface. It accepts one decoded system instruction at a time (csrrw, csrrs, ecall, mret) over a valid/ready handshake. It drives the CSR file's read/write port and its `intr`/`intr_NO`/`intr_epc` inputs, and consumes `intr_mtvec`/`mret_mepc`. It returns the rd writeback value and the next-PC redirect to the WBU over a second valid/ready handshake.

## Interface
- `DATA_WIDTH`, 32, width of PC, CSR data and CSR address buses
- `clk` in 1: single clock, rising edge
- `rst` in 1: asynchronous, active-high reset
- `in_valid` in 1: decoded instruction valid
- `in_ready` out 1: high only in IDLE
- `op` in 2: 00 csrrw, 01 csrrs, 10 ecall, 11 mret
- `csr_idx` in 12: instruction CSR field
- `rs1_data` in DATA_WIDTH: source operand
- `rs1_zero` in 1: rs1 field is x0
- `pc` in DATA_WIDTH: instruction PC
- `csr_wen` out 1: CSR write enable
- `csr_addr` out DATA_WIDTH: zero-extended CSR index
- `csr_wdata` out DATA_WIDTH: CSR write data
- `csr_rdata` in DATA_WIDTH: CSR read data, combinational on `csr_addr`
- `intr` out 1: trap strobe
- `intr_NO` out DATA_WIDTH: mcause value
- `intr_epc` out DATA_WIDTH: faulting PC
- `intr_mtvec` in DATA_WIDTH: current mtvec
- `mret_mepc` in DATA_WIDTH: current mepc
- `out_valid` out 1: result valid
- `out_ready` in 1: WBU accepts result
- `rd_wen` out 1: write rd
- `rd_wdata` out DATA_WIDTH: old CSR value
- `redirect` out 1: take `redirect_pc` instead of pc+4
- `redirect_pc` out DATA_WIDTH: trap/return target

## Operation
- States: IDLE, RD, WR, TRAP, RESP. Reset → IDLE, all registers 0.
- Accept on `in_valid && in_ready`. Latch `op`, `csr_idx`, `rs1_data`, `rs1_zero` and `pc`.
- Legal CSR indices: 0x300, 0x305, 0x341, 0x342. Any other index on csrrw/csrrs sets cause=2 (illegal instruction).
- IDLE → TRAP for ecall (cause=11) or an illegal CSR access (cause=2); otherwise IDLE → RD.
- RD: `csr_addr` = latched index (mret: 0x300). Capture `csr_rdata` into `old`. → WR.
- WR: `csr_wen`=1 with `csr_wdata` as follows:
  - csrrw: `rs1_data`
  - csrrs: `old | rs1_data`
  - mret: `old` with [3]←old[7], [7]←1, [12:11]←2'b11
  - Exception: csrrs with `rs1_zero` keeps `csr_wen`=0.
  - → RESP.
- TRAP: `intr`=1, `intr_NO`=cause, `intr_epc`=latched pc. Capture `intr_mtvec` into target. → RESP.
- RESP: `out_valid`=1, outputs held stable until `out_ready`. Then → IDLE.
- RESP output values:
  - csr ops: `rd_wen`=1, `rd_wdata`=old, `redirect`=0.
  - ecall/illegal: `rd_wen`=0, `redirect`=1, `redirect_pc`=target.
  - mret: `rd_wen`=0, `redirect`=1, `redirect_pc`=`mret_mepc` sampled in RD.
- `csr_wen` and `intr` are never high in the same cycle; the CSR file gives wen priority and would drop the trap.
- `csr_addr` outside RD/WR = 0.

## Timing
- Reset values: `in_ready`=1. `csr_wen`, `intr`, `out_valid`, `rd_wen` and `redirect` = 0. All buses = 0.
- `rst` asserted mid-sequence forces IDLE asynchronously. No CSR write or trap strobe may occur in or after the reset cycle.
- csr ops and mret: accept edge E0; RD in cycle 1, WR in cycle 2, `out_valid` rises in cycle 3.
- ecall/illegal: TRAP in cycle 1, `out_valid` rises in cycle 2.
- `csr_wen` and `intr` are single-cycle pulses, exactly one per instruction.
- RESP → IDLE on the out-handshake edge. The next `in_valid` is accepted one cycle later; there is no accept during RESP.
- Stalling `out_ready` low for N cycles extends RESP by N and produces no extra CSR activity.
- Outputs are registered state decodes. The only combinational paths are `csr_rdata`, `intr_mtvec` and `mret_mepc` sampling into internal registers.

## Test plan
- Reset then csrrw 0x305, rs1=0x8000_0100, mtvec=0 → `csr_wen` pulse in cycle 2 with wdata 0x8000_0100; RESP: `rd_wdata`=0, `redirect`=0; the next read of mtvec returns 0x8000_0100.
- csrrs 0x300, rs1=0x8, mstatus=0x1800 → wdata 0x1808, `rd_wdata`=0x1800. Repeat with `rs1_zero`=1 → no `csr_wen` pulse, `rd_wdata`=0x1808.
- ecall at pc=0x8000_0040, mtvec=0x8000_0100 → `intr` pulse in cycle 1 with `intr_NO`=11, `intr_epc`=0x8000_0040; `csr_wen` stays 0; RESP `redirect_pc`=0x8000_0100.
- mret with mstatus=0x1880 and mepc=0x8000_0044 → write 0x1888 to 0x300; RESP `redirect`=1, `redirect_pc`=0x8000_0044.
- csrrw to 0x7C0 → trap with `intr_NO`=2, no CSR write, `rd_wen`=0.
- Hold `out_ready`=0 for 5 cycles in RESP → outputs stable, `in_ready`=0. Assert `rst` during WR of a csrrw → no write observed, all outputs at reset values, `in_ready`=1.
